// File: rtl/jtvigil_obj_linebuf.sv
`default_nettype none
// ============================================================================
// Module   : jtvigil_obj_linebuf
// Brief    : Double-buffered object line buffer. One bank is filled by the
//            sprite drawer while the other is read out at pixel rate and
//            erased behind the read. Banks swap at the start of every H blank.
// Revision : 1.0 - initial release
// ============================================================================
module jtvigil_obj_linebuf #(
    parameter int DW    = 8,     // pixel word width, {palette, colour}
    parameter int AW    = 9,     // line address width
    parameter int ALPHA = 0,     // transparent colour code
    parameter bit PRIO  = 1'b0   // 1: first opaque write to an address wins
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LHBL,
    input  logic          flip,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          we,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd,
    output logic [DW-1:0] rd_data,
    output logic          ready
);

    localparam int            c_depth = 1 << AW;
    localparam logic [3:0]    c_alpha = 4'(ALPHA);
    localparam logic [DW-1:0] c_blank = DW'(ALPHA);

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [0:0]    r_state;
    logic [AW-1:0] r_clr_addr;
    logic          r_ready;
    logic          r_bank;      // read bank; the write bank is its complement
    logic          r_lhbl_l;
    logic          r_rd_bank;   // bank that produced the current rd_data

    // Write pipeline used when PRIO=1 (S1 = pending write, S2 = last write)
    logic          r_s1_vld;
    logic [AW-1:0] r_s1_addr;
    logic [DW-1:0] r_s1_data;
    logic          r_s1_bank;
    logic          r_s2_vld;
    logic [AW-1:0] r_s2_addr;
    logic [DW-1:0] r_s2_data;
    logic          r_s2_bank;

    logic          w_run;
    logic          w_swap;
    logic          w_opaque;
    logic          w_wr_go;
    logic          w_rd_go;
    logic [AW-1:0] w_rd_a;
    logic          w_fwd;
    logic [DW-1:0] w_s1_stored;
    logic          w_s1_write;

    // Per-bank memory port controls
    logic [1:0]          w_a_we;
    logic [1:0]          w_a_re;
    logic [AW-1:0]       w_a_waddr;
    logic [DW-1:0]       w_a_din;
    logic [1:0]          w_b_en;
    logic [1:0][DW-1:0]  w_qa;
    logic [1:0][DW-1:0]  w_qb;

    assign w_run    = (r_state == c_st_run);
    assign w_swap   = r_lhbl_l & ~LHBL;
    assign w_opaque = (wr_data[3:0] != c_alpha);
    assign w_wr_go  = rst_n & we & w_run & w_opaque;
    assign w_rd_go  = rst_n & rd & w_run;
    assign w_rd_a   = flip ? ~rd_addr : rd_addr;

    // The previous S1 write has not been seen by the S0 read of the same
    // address (read-before-write), so its data is forwarded instead.
    assign w_fwd       = r_s2_vld && (r_s2_addr == r_s1_addr) && (r_s2_bank == r_s1_bank);
    assign w_s1_stored = w_fwd ? r_s2_data : w_qa[r_s1_bank];
    assign w_s1_write  = r_s1_vld && (w_s1_stored[3:0] == c_alpha);

    // Line-blank edge detector, free running
    always_ff @(posedge clk) begin
        r_lhbl_l <= LHBL;
    end

    // Clear sweep FSM, bank toggle and read-bank tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_clear;
            r_clr_addr <= '0;
            r_ready    <= 1'b0;
            r_bank     <= 1'b0;
            r_rd_bank  <= 1'b0;
        end else begin
            if (w_swap) begin
                r_bank <= ~r_bank;
            end
            if (w_rd_go) begin
                r_rd_bank <= r_bank;
            end
            case (r_state)
                c_st_clear: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (&r_clr_addr) begin
                        r_state <= c_st_run;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_run;
                end
            endcase
        end
    end

    // Priority write pipeline: S0 captures the request, S1 decides on it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_data <= c_blank;
            r_s1_bank <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_data <= c_blank;
            r_s2_bank <= 1'b0;
        end else begin
            r_s1_vld <= PRIO && w_wr_go;
            if (w_wr_go) begin
                r_s1_addr <= wr_addr;
                r_s1_data <= wr_data;
                r_s1_bank <= ~r_bank;
            end
            r_s2_vld  <= w_s1_write;
            r_s2_addr <= r_s1_addr;
            r_s2_data <= r_s1_data;
            r_s2_bank <= r_s1_bank;
        end
    end

    // Port A steering: clear sweep, direct write or pipelined priority write
    always_comb begin
        w_a_we    = 2'b00;
        w_a_re    = 2'b00;
        w_a_waddr = wr_addr;
        w_a_din   = wr_data;
        if (!rst_n) begin
            w_a_we = 2'b00;
        end else if (!w_run) begin
            w_a_we    = 2'b11;
            w_a_waddr = r_clr_addr;
            w_a_din   = c_blank;
        end else if (PRIO) begin
            w_a_we[r_s1_bank] = w_s1_write;
            w_a_waddr         = r_s1_addr;
            w_a_din           = r_s1_data;
            w_a_re[~r_bank]   = w_wr_go;
        end else begin
            w_a_we[~r_bank] = w_wr_go;
        end
    end

    // Port B: read-and-erase on the current read bank only
    always_comb begin
        w_b_en         = 2'b00;
        w_b_en[r_bank] = w_rd_go;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [DW-1:0] r_mem [0:c_depth-1];
        logic [DW-1:0] r_qa;
        logic [DW-1:0] r_qb;

        // Memory array writes: port A (fill/clear) and port B (erase)
        always_ff @(posedge clk) begin
            if (w_a_we[b]) begin
                r_mem[w_a_waddr] <= w_a_din;
            end
            if (w_b_en[b]) begin
                r_mem[w_rd_a] <= c_blank;
            end
        end

        // Port A read for the priority check, old contents
        always_ff @(posedge clk) begin
            if (w_a_re[b]) begin
                r_qa <= r_mem[wr_addr];
            end
        end

        // Port B read register, old contents, blank after reset
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_qb <= c_blank;
            end else if (w_b_en[b]) begin
                r_qb <= r_mem[w_rd_a];
            end
        end

        assign w_qa[b] = r_qa;
        assign w_qb[b] = r_qb;
    end

    assign rd_data = w_qb[r_rd_bank];
    assign ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_jtvigil_obj_linebuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtvigil_obj_linebuf
// Brief    : Directed bench for the object line buffer; two instances, one
//            with later-write-wins and one with first-opaque-wins priority.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtvigil_obj_linebuf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       LHBL = 1'b1;
    logic       flip = 1'b0;
    logic       we = 1'b0;
    logic       rd = 1'b0;
    logic [8:0] wr_addr = '0;
    logic [8:0] rd_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data0, rd_data1;
    logic       ready0, ready1;

    int errors = 0;
    int checks = 0;

    jtvigil_obj_linebuf #(.DW(8), .AW(9), .ALPHA(0), .PRIO(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .LHBL(LHBL), .flip(flip),
        .wr_addr(wr_addr), .wr_data(wr_data), .we(we),
        .rd_addr(rd_addr), .rd(rd), .rd_data(rd_data0), .ready(ready0)
    );

    jtvigil_obj_linebuf #(.DW(8), .AW(9), .ALPHA(0), .PRIO(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .LHBL(LHBL), .flip(flip),
        .wr_addr(wr_addr), .wr_data(wr_data), .we(we),
        .rd_addr(rd_addr), .rd(rd), .rd_data(rd_data1), .ready(ready1)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [8:0] a, input logic [7:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic swap();
        tick();
        LHBL = 1'b0;
        tick();
        tick();
        LHBL = 1'b1;
        tick();
    endtask

    task automatic get(input logic [8:0] a);
        rd = 1'b1; rd_addr = a;
        tick();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL rst_ready_p0: got %b want 0", ready0); end
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready_p1: got %b want 0", ready1); end
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL rst_data_p0: got %02h want 00", rd_data0); end
        checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL rst_data_p1: got %02h want 00", rd_data1); end
        rst_n = 1'b1;
        for (int i = 1; i <= 512; i++) begin
            tick();
            if (i == 1 || i == 511) begin
                checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL clear_busy_p0 cyc %0d: got %b want 0", i, ready0); end
                checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL clear_busy_p1 cyc %0d: got %b want 0", i, ready1); end
            end
        end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL clear_done_p0: got %b want 1", ready0); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL clear_done_p1: got %b want 1", ready1); end
    endtask

    task automatic test_clear_contents();
        swap();
        for (int a = 0; a < 512; a++) begin
            rd = 1'b1; rd_addr = 9'(a);
            tick();
            checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL blank_p0 @%03h: got %02h want 00", a, rd_data0); end
            checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL blank_p1 @%03h: got %02h want 00", a, rd_data1); end
        end
        rd = 1'b0;
    endtask

    task automatic test_write_read();
        put(9'h120, 8'h5A);
        swap();
        get(9'h120);
        checks++; if (rd_data0 !== 8'h5A) begin errors++; $display("FAIL wr_rd_p0: got %02h want 5a", rd_data0); end
        checks++; if (rd_data1 !== 8'h5A) begin errors++; $display("FAIL wr_rd_p1: got %02h want 5a", rd_data1); end
        tick();
        checks++; if (rd_data0 !== 8'h5A) begin errors++; $display("FAIL rd_hold_p0: got %02h want 5a", rd_data0); end
        get(9'h120);
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL erase_same_p0: got %02h want 00", rd_data0); end
        checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL erase_same_p1: got %02h want 00", rd_data1); end
        swap();
        get(9'h120);
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL next_line_p0: got %02h want 00", rd_data0); end
        swap();
        get(9'h120);
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL erased_bank_p0: got %02h want 00", rd_data0); end
        checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL erased_bank_p1: got %02h want 00", rd_data1); end
    endtask

    task automatic test_transparent();
        put(9'h010, 8'h30);
        swap();
        get(9'h010);
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL alpha_p0: got %02h want 00", rd_data0); end
        checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL alpha_p1: got %02h want 00", rd_data1); end
        put(9'h010, 8'h31);
        swap();
        get(9'h010);
        checks++; if (rd_data0 !== 8'h31) begin errors++; $display("FAIL opaque_p0: got %02h want 31", rd_data0); end
        checks++; if (rd_data1 !== 8'h31) begin errors++; $display("FAIL opaque_p1: got %02h want 31", rd_data1); end
    endtask

    task automatic test_back_to_back();
        // same address, consecutive cycles
        we = 1'b1; wr_addr = 9'h005; wr_data = 8'h21;
        tick();
        wr_data = 8'h45;
        tick();
        // same address with an idle cycle between
        wr_addr = 9'h006; wr_data = 8'h13;
        tick();
        we = 1'b0;
        tick();
        we = 1'b1; wr_data = 8'h6E;
        tick();
        // transparent first, then opaque
        wr_addr = 9'h007; wr_data = 8'h20;
        tick();
        wr_data = 8'h45;
        tick();
        we = 1'b0;
        swap();
        get(9'h005);
        checks++; if (rd_data0 !== 8'h45) begin errors++; $display("FAIL b2b_p0: got %02h want 45", rd_data0); end
        checks++; if (rd_data1 !== 8'h21) begin errors++; $display("FAIL b2b_p1: got %02h want 21", rd_data1); end
        get(9'h006);
        checks++; if (rd_data0 !== 8'h6E) begin errors++; $display("FAIL gap_p0: got %02h want 6e", rd_data0); end
        checks++; if (rd_data1 !== 8'h13) begin errors++; $display("FAIL gap_p1: got %02h want 13", rd_data1); end
        get(9'h007);
        checks++; if (rd_data0 !== 8'h45) begin errors++; $display("FAIL alpha_first_p0: got %02h want 45", rd_data0); end
        checks++; if (rd_data1 !== 8'h45) begin errors++; $display("FAIL alpha_first_p1: got %02h want 45", rd_data1); end
    endtask

    task automatic test_flip();
        flip = 1'b1;
        put(9'h000, 8'h7C);
        swap();
        get(9'h1FF);
        checks++; if (rd_data0 !== 8'h7C) begin errors++; $display("FAIL flip_hit_p0: got %02h want 7c", rd_data0); end
        checks++; if (rd_data1 !== 8'h7C) begin errors++; $display("FAIL flip_hit_p1: got %02h want 7c", rd_data1); end
        get(9'h000);
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL flip_miss_p0: got %02h want 00", rd_data0); end
        get(9'h1FF);
        checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL flip_erase_p1: got %02h want 00", rd_data1); end
        flip = 1'b0;
    endtask

    task automatic test_reset_midline();
        int n;
        put(9'h040, 8'h66);
        put(9'h041, 8'h55);
        swap();
        put(9'h041, 8'h44);
        we = 1'b1; wr_addr = 9'h042; wr_data = 8'h77;
        rd = 1'b1; rd_addr = 9'h040;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL mid_rst_ready_p0: got %b want 0", ready0); end
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL mid_rst_ready_p1: got %b want 0", ready1); end
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL mid_rst_data_p0: got %02h want 00", rd_data0); end
        rst_n = 1'b1;
        wr_addr = 9'h040; wr_data = 8'h99;
        n = 0;
        while (!(ready0 && ready1) && n < 700) begin
            tick();
            n++;
            if (n == 50) begin
                checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL clear_rd_p0: got %02h want 00", rd_data0); end
                checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL clear_rd_p1: got %02h want 00", rd_data1); end
            end
            if (n == 100) begin
                we = 1'b0;
                rd = 1'b0;
            end
        end
        checks++; if (n !== 512) begin errors++; $display("FAIL reclear_len: got %0d cycles want 512", n); end
        for (int k = 0; k < 2; k++) begin
            get(9'h040);
            checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL old40_p0 pass %0d: got %02h want 00", k, rd_data0); end
            checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL old40_p1 pass %0d: got %02h want 00", k, rd_data1); end
            get(9'h041);
            checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL old41_p0 pass %0d: got %02h want 00", k, rd_data0); end
            checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL old41_p1 pass %0d: got %02h want 00", k, rd_data1); end
            get(9'h042);
            checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL old42_p1 pass %0d: got %02h want 00", k, rd_data1); end
            swap();
        end
    endtask

    initial begin
        test_reset();
        test_clear_contents();
        test_write_read();
        test_transparent();
        test_back_to_back();
        test_flip();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
